video_timing_gen: RTL
=====================

# video_timing_gen

Runtime-reconfigurable video timing generator that drives the HDMI transmitter path. It produces the pixel/line counters, sync pulses, data-enable and frame markers for any CEA/VESA-style raster up to 2^H_BITS × 2^V_BITS. It powers up in a parameter-defined default mode (720p60). Software can load a new mode over a valid/ready port, and the new mode takes effect cleanly at the next frame boundary.

## Interface
- `H_BITS`, 12, width of horizontal fields and `hcount_o`
- `V_BITS`, 11, width of vertical fields and `vcount_o`
- `FC_BITS`, 6, frame counter width
- `DEF_H_ACTIVE`/`DEF_H_FP`/`DEF_H_SYNC`/`DEF_H_BP`, 1280/110/40/220, default horizontal timing
- `DEF_V_ACTIVE`/`DEF_V_FP`/`DEF_V_SYNC`/`DEF_V_BP`, 720/5/5/20, default vertical timing
- `DEF_HS_POL`, `DEF_VS_POL`, 1/1, default sync polarity (1 = active-high)
- `pixel_clk_i` in 1: the single clock
- `rst_n_i` in 1: reset, synchronous, active-low
- `cfg_valid_i` in 1: new-mode request
- `cfg_ready_o` out 1: shadow register free
- `cfg_h_active_i`, `cfg_h_fp_i`, `cfg_h_sync_i`, `cfg_h_bp_i` in H_BITS each: horizontal fields
- `cfg_v_active_i`, `cfg_v_fp_i`, `cfg_v_sync_i`, `cfg_v_bp_i` in V_BITS each: vertical fields
- `cfg_hs_pol_i`, `cfg_vs_pol_i` in 1: sync polarity
- `hcount_o` out H_BITS: pixel position in line
- `vcount_o` out V_BITS: line position in frame
- `hs_o` out 1: horizontal sync
- `vs_o` out 1: vertical sync
- `de_o` out 1: active video
- `sof_o` out 1: one-cycle pulse at (0,0)
- `eol_o` out 1: one-cycle pulse on the last active pixel of each active line
- `fc_o` out FC_BITS: frame counter

## Operation
- Line and frame totals: H_TOTAL = active + fp + sync + bp, and likewise V_TOTAL. Both are computed at load time with one extra guard bit.
- Legal modes: active ≥ 1 and sync ≥ 1; porches may be 0.
- Any mode with H_TOTAL > 2^H_BITS or V_TOTAL > 2^V_BITS is illegal, and its behaviour is undefined.
- Raster order: h counts 0..H_TOTAL-1. On wrap, v increments, and v counts 0..V_TOTAL-1.
- `de_o` = (h < h_active) && (v < v_active).
- `hs_o` is active for exactly h_sync pixels, over h in [h_active+h_fp, h_active+h_fp+h_sync-1]. `vs_o` follows the same rule over lines.
- Each sync output's active level equals its polarity bit. Its idle level is the inverse.
- `fc_o` increments on every `sof_o` and wraps modulo 2^FC_BITS.
- Two timing register sets: LIVE (drives the raster) and SHADOW (pending).
  - A config is accepted when `cfg_valid_i && cfg_ready_o`. On acceptance all fields are copied to SHADOW and `cfg_ready_o` drops.
  - SHADOW is applied to LIVE at the frame-wrap edge, i.e. the edge where (h,v) goes from (H_TOTAL-1, V_TOTAL-1) to (0,0). Pixel (0,0) is therefore the first pixel of the new mode.
  - `cfg_ready_o` reasserts in the cycle after the apply edge.
  - A config accepted during the last pixel of a frame applies at the next frame wrap, not the current one.
- Reset, or reset asserted mid-frame or mid-pending:
  - counters → idle, SHADOW is discarded, LIVE reloads the DEF_* parameters.

## Timing
- Reset values: `hcount_o`=0, `vcount_o`=0, `de_o`=0, `sof_o`=0, `eol_o`=0, `fc_o`=0, `cfg_ready_o`=1.
- Reset values, syncs: `hs_o` = ~DEF_HS_POL and `vs_o` = ~DEF_VS_POL (idle level).
- All outputs are flops. hs/vs/de/sof/eol always describe the (`hcount_o`,`vcount_o`) shown in the same cycle (zero skew).
- First edge with `rst_n_i`=1: outputs show (0,0), `de_o`=1, `sof_o`=1, `fc_o`=0. `fc_o` becomes 1 at the following `sof_o`.
- Config latency: accept-to-apply is at most one frame plus one cycle.
- `cfg_valid_i` is ignored while `cfg_ready_o`=0. No field may change LIVE mid-frame.

## Configuration
- `VTG_PATTERN_EN` defined: adds input `pattern_en_i` (1 bit) and output `rgb_o` (24 bits), both registered and aligned with `de_o`.
  - Pattern: 8 vertical colour bars, each h_active>>3 pixels wide. The bar index saturates at 7 for remainder pixels.
  - Bar colours in order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - `rgb_o`=0 when `de_o`=0 or `pattern_en_i`=0. Reset value is 0.
- `VTG_PATTERN_EN` undefined: neither port exists and no pattern logic is built.

## Test plan
- Defaults, reset then 2 frames: `hs_o` is high 40 clocks, starting at h=1390. `vs_o` is high for 5 lines, starting at v=725. H_TOTAL=1650 and V_TOTAL=750 clocks/lines. `sof_o` pulses every 1 237 500 clocks. `fc_o` reads 0→1.
- Small mode (h 8/2/3/1, v 4/1/2/1, pol 0/0) loaded, wait for apply:
  - `cfg_ready_o` is low until the wrap, then the next frame has H_TOTAL=14 and V_TOTAL=8.
  - `de_o` is 8 clocks per line on 4 lines; `hs_o` is low for h=10..12; `vs_o` is low for v=5..6.
  - `eol_o` pulses at h=7 on v=0..3.
- Config accepted in the cycle (H_TOTAL-1, V_TOTAL-1): the current wrap keeps the old mode, and the mode changes exactly one frame later.
- `cfg_valid_i` held high with a second config while `cfg_ready_o`=0: the second config is ignored, and only the first mode appears.
- `rst_n_i` pulsed low mid-frame with a config pending: all outputs go to their reset values, the default mode resumes, and `cfg_ready_o`=1.
- With `VTG_PATTERN_EN`, small mode, `pattern_en_i`=1: `rgb_o` shows FFFFFF at h=0 and 000000 at h=7, and is 0 during blanking. With `pattern_en_i`=0, `rgb_o` is always 0.

Source files
------------

// File: rtl/video_timing_gen_if.sv
// -----------------------------------------------------------------------------
// video_timing_gen_if
// Mode-load port of the video timing generator: a valid/ready handshake
// that carries one complete raster description.
//
// Signals
//   cfg_valid               master -> slave  new-mode request
//   cfg_ready               slave  -> master shadow register free
//   cfg_h_active/fp/sync/bp master -> slave  horizontal fields (H_BITS)
//   cfg_v_active/fp/sync/bp master -> slave  vertical fields (V_BITS)
//   cfg_hs_pol/cfg_vs_pol   master -> slave  sync polarity (1 = active-high)
// -----------------------------------------------------------------------------
interface video_timing_gen_if #(
  parameter int H_BITS = 12,
  parameter int V_BITS = 11
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [H_BITS-1:0] cfg_h_active;
  logic [H_BITS-1:0] cfg_h_fp;
  logic [H_BITS-1:0] cfg_h_sync;
  logic [H_BITS-1:0] cfg_h_bp;
  logic [V_BITS-1:0] cfg_v_active;
  logic [V_BITS-1:0] cfg_v_fp;
  logic [V_BITS-1:0] cfg_v_sync;
  logic [V_BITS-1:0] cfg_v_bp;
  logic              cfg_hs_pol;
  logic              cfg_vs_pol;

  modport master (
    output cfg_valid,
    output cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
    output cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp,
    output cfg_hs_pol, cfg_vs_pol,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
    input  cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp,
    input  cfg_hs_pol, cfg_vs_pol,
    output cfg_ready
  );
endinterface

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
// Runtime-reconfigurable raster timing generator for the HDMI transmit path.
// Produces pixel/line counters, sync pulses, data enable, start-of-frame and
// end-of-active-line markers plus a frame counter. Powers up in the DEF_*
// mode; a new mode loaded through cfg_if is held in a shadow set and copied
// into the live set on the frame-wrap edge, so every frame is uniform.
//
// Ports
//   pixel_clk_i  in   pixel clock
//   rst_n_i      in   synchronous active-low reset
//   cfg_if       slave  mode-load handshake (see video_timing_gen_if)
//   hcount_o     out  pixel position in line   (H_BITS)
//   vcount_o     out  line position in frame   (V_BITS)
//   hs_o / vs_o  out  horizontal / vertical sync, level set by polarity bit
//   de_o         out  active video
//   sof_o        out  one-cycle pulse at pixel (0,0)
//   eol_o        out  one-cycle pulse on last active pixel of active lines
//   fc_o         out  frame counter (FC_BITS, wraps)
//   pattern_en_i in   colour-bar enable       (only with VTG_PATTERN_EN)
//   rgb_o        out  colour-bar pixel, 24 bit (only with VTG_PATTERN_EN)
//
// Build option: define VTG_PATTERN_EN to add the colour-bar test pattern.
// All outputs are registered and describe the pixel shown in the same cycle.
// -----------------------------------------------------------------------------
module video_timing_gen #(
  parameter int H_BITS       = 12,
  parameter int V_BITS       = 11,
  parameter int FC_BITS      = 6,
  parameter int DEF_H_ACTIVE = 1280,
  parameter int DEF_H_FP     = 110,
  parameter int DEF_H_SYNC   = 40,
  parameter int DEF_H_BP     = 220,
  parameter int DEF_V_ACTIVE = 720,
  parameter int DEF_V_FP     = 5,
  parameter int DEF_V_SYNC   = 5,
  parameter int DEF_V_BP     = 20,
  parameter bit DEF_HS_POL   = 1'b1,
  parameter bit DEF_VS_POL   = 1'b1
) (
  input  logic               pixel_clk_i,
  input  logic               rst_n_i,
  video_timing_gen_if.slave  cfg_if,
  output logic [H_BITS-1:0]  hcount_o,
  output logic [V_BITS-1:0]  vcount_o,
  output logic               hs_o,
  output logic               vs_o,
  output logic               de_o,
  output logic               sof_o,
  output logic               eol_o,
  output logic [FC_BITS-1:0] fc_o
`ifdef VTG_PATTERN_EN
  ,
  input  logic               pattern_en_i,
  output logic [23:0]        rgb_o
`endif
);

  // One raster description. Back porch is only needed for the totals, which
  // are computed once at load time with a guard bit.
  typedef struct packed {
    logic [H_BITS-1:0] h_active;
    logic [H_BITS-1:0] h_fp;
    logic [H_BITS-1:0] h_sync;
    logic [H_BITS:0]   h_total;
    logic [V_BITS-1:0] v_active;
    logic [V_BITS-1:0] v_fp;
    logic [V_BITS-1:0] v_sync;
    logic [V_BITS:0]   v_total;
    logic              hs_pol;
    logic              vs_pol;
  } mode_t;

  typedef enum logic [0:0] {
    CFG_IDLE = 1'b0,
    CFG_PEND = 1'b1
  } cfg_state_e;

  localparam mode_t DEF_MODE = '{
    h_active: H_BITS'(DEF_H_ACTIVE),
    h_fp:     H_BITS'(DEF_H_FP),
    h_sync:   H_BITS'(DEF_H_SYNC),
    h_total:  (H_BITS+1)'(DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP),
    v_active: V_BITS'(DEF_V_ACTIVE),
    v_fp:     V_BITS'(DEF_V_FP),
    v_sync:   V_BITS'(DEF_V_SYNC),
    v_total:  (V_BITS+1)'(DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP),
    hs_pol:   DEF_HS_POL,
    vs_pol:   DEF_VS_POL
  };

  // Build a mode record from raw fields, widening before the sums so a
  // full 2^BITS total still fits.
  function automatic mode_t pack_mode(
    input logic [H_BITS-1:0] ha, input logic [H_BITS-1:0] hf,
    input logic [H_BITS-1:0] hs, input logic [H_BITS-1:0] hb,
    input logic [V_BITS-1:0] va, input logic [V_BITS-1:0] vf,
    input logic [V_BITS-1:0] vs, input logic [V_BITS-1:0] vb,
    input logic hp, input logic vp
  );
    mode_t m;
    m.h_active = ha;
    m.h_fp     = hf;
    m.h_sync   = hs;
    m.h_total  = (H_BITS+1)'(ha) + (H_BITS+1)'(hf) + (H_BITS+1)'(hs) + (H_BITS+1)'(hb);
    m.v_active = va;
    m.v_fp     = vf;
    m.v_sync   = vs;
    m.v_total  = (V_BITS+1)'(va) + (V_BITS+1)'(vf) + (V_BITS+1)'(vs) + (V_BITS+1)'(vb);
    m.hs_pol   = hp;
    m.vs_pol   = vp;
    return m;
  endfunction

  // State
  cfg_state_e         cfg_state_q, cfg_state_d;
  mode_t              live_q, live_d;
  mode_t              shadow_q, shadow_d;
  logic               ready_q, ready_d;
  logic               run_q, run_d;
  logic [H_BITS-1:0]  hcount_q, hcount_d;
  logic [V_BITS-1:0]  vcount_q, vcount_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic               de_q, de_d;
  logic               sof_q, sof_d;
  logic               eol_q, eol_d;
  logic [FC_BITS-1:0] fc_q, fc_d;

  // Combinational helpers
  logic               h_last_s;
  logic               v_last_s;
  logic               wrap_s;
  logic               apply_s;
  mode_t              mode_s;
  logic [H_BITS:0]    hs_start_s, hs_stop_s;
  logic [V_BITS:0]    vs_start_s, vs_stop_s;
  logic               h_in_sync_s;
  logic               v_in_sync_s;

  // Next raster position, frame-wrap detection and the mode that governs
  // the next pixel (shadow on the apply edge, otherwise live).
  always_comb begin
    h_last_s = ({1'b0, hcount_q} == (live_q.h_total - (H_BITS+1)'(1)));
    v_last_s = ({1'b0, vcount_q} == (live_q.v_total - (V_BITS+1)'(1)));
    wrap_s   = run_q && h_last_s && v_last_s;
    apply_s  = wrap_s && (cfg_state_q == CFG_PEND);
    run_d    = 1'b1;

    // First cycle out of reset shows (0,0) rather than advancing
    if (!run_q) begin
      hcount_d = {H_BITS{1'b0}};
      vcount_d = {V_BITS{1'b0}};
    end else if (h_last_s) begin
      hcount_d = {H_BITS{1'b0}};
      if (v_last_s) begin
        vcount_d = {V_BITS{1'b0}};
      end else begin
        vcount_d = vcount_q + V_BITS'(1);
      end
    end else begin
      hcount_d = hcount_q + H_BITS'(1);
      vcount_d = vcount_q;
    end

    if (apply_s) begin
      mode_s = shadow_q;
    end else begin
      mode_s = live_q;
    end
    live_d = mode_s;

    // The very first (0,0) after reset keeps fc at 0
    if (wrap_s) begin
      fc_d = fc_q + FC_BITS'(1);
    end else begin
      fc_d = fc_q;
    end
  end

  // Sync, data-enable and marker decode for the pixel about to be shown
  always_comb begin
    hs_start_s  = (H_BITS+1)'(mode_s.h_active) + (H_BITS+1)'(mode_s.h_fp);
    hs_stop_s   = hs_start_s + (H_BITS+1)'(mode_s.h_sync);
    vs_start_s  = (V_BITS+1)'(mode_s.v_active) + (V_BITS+1)'(mode_s.v_fp);
    vs_stop_s   = vs_start_s + (V_BITS+1)'(mode_s.v_sync);
    h_in_sync_s = ((H_BITS+1)'(hcount_d) >= hs_start_s) && ((H_BITS+1)'(hcount_d) < hs_stop_s);
    v_in_sync_s = ((V_BITS+1)'(vcount_d) >= vs_start_s) && ((V_BITS+1)'(vcount_d) < vs_stop_s);

    de_d  = (hcount_d < mode_s.h_active) && (vcount_d < mode_s.v_active);
    sof_d = (hcount_d == {H_BITS{1'b0}}) && (vcount_d == {V_BITS{1'b0}});
    eol_d = de_d && (hcount_d == (mode_s.h_active - H_BITS'(1)));

    if (h_in_sync_s) begin
      hs_d = mode_s.hs_pol;
    end else begin
      hs_d = ~mode_s.hs_pol;
    end

    if (v_in_sync_s) begin
      vs_d = mode_s.vs_pol;
    end else begin
      vs_d = ~mode_s.vs_pol;
    end
  end

  // Config handshake FSM: IDLE accepts into shadow, PEND waits for frame wrap
  always_comb begin
    cfg_state_d = cfg_state_q;
    shadow_d    = shadow_q;
    case (cfg_state_q)
      CFG_IDLE: begin
        if (cfg_if.cfg_valid) begin
          shadow_d    = pack_mode(cfg_if.cfg_h_active, cfg_if.cfg_h_fp,
                                  cfg_if.cfg_h_sync,   cfg_if.cfg_h_bp,
                                  cfg_if.cfg_v_active, cfg_if.cfg_v_fp,
                                  cfg_if.cfg_v_sync,   cfg_if.cfg_v_bp,
                                  cfg_if.cfg_hs_pol,   cfg_if.cfg_vs_pol);
          cfg_state_d = CFG_PEND;
        end else begin
          cfg_state_d = CFG_IDLE;
        end
      end
      CFG_PEND: begin
        // A config accepted on the last pixel is not yet PEND at that wrap,
        // so it naturally waits for the following one.
        if (wrap_s) begin
          cfg_state_d = CFG_IDLE;
        end else begin
          cfg_state_d = CFG_PEND;
        end
      end
      default: begin
        cfg_state_d = CFG_IDLE;
      end
    endcase
    ready_d = (cfg_state_d == CFG_IDLE);
  end

  // State and output registers; reset restores the default mode and drops
  // any pending shadow contents.
  always_ff @(posedge pixel_clk_i) begin
    if (!rst_n_i) begin
      cfg_state_q <= CFG_IDLE;
      live_q      <= DEF_MODE;
      shadow_q    <= DEF_MODE;
      ready_q     <= 1'b1;
      run_q       <= 1'b0;
      hcount_q    <= {H_BITS{1'b0}};
      vcount_q    <= {V_BITS{1'b0}};
      hs_q        <= ~DEF_HS_POL;
      vs_q        <= ~DEF_VS_POL;
      de_q        <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      fc_q        <= {FC_BITS{1'b0}};
    end else begin
      cfg_state_q <= cfg_state_d;
      live_q      <= live_d;
      shadow_q    <= shadow_d;
      ready_q     <= ready_d;
      run_q       <= run_d;
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      de_q        <= de_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      fc_q        <= fc_d;
    end
  end

  assign cfg_if.cfg_ready = ready_q;
  assign hcount_o         = hcount_q;
  assign vcount_o         = vcount_q;
  assign hs_o             = hs_q;
  assign vs_o             = vs_q;
  assign de_o             = de_q;
  assign sof_o            = sof_q;
  assign eol_o            = eol_q;
  assign fc_o             = fc_q;

`ifdef VTG_PATTERN_EN
  localparam int PW = H_BITS + 4;

  logic [PW-1:0] bar_w_s;
  logic [2:0]    bar_idx_s;
  logic [23:0]   bar_rgb_s;
  logic [23:0]   rgb_q, rgb_d;

  // Colour-bar pick: count the bar boundaries the next pixel has passed,
  // which saturates at 7 for remainder pixels without a divider.
  always_comb begin
    bar_w_s   = PW'(mode_s.h_active >> 3);
    bar_idx_s = 3'd0;
    for (int k = 1; k < 8; k++) begin
      bar_idx_s = bar_idx_s + {2'b00, (PW'(hcount_d) >= (bar_w_s * PW'(k)))};
    end

    case (bar_idx_s)
      3'd0:    bar_rgb_s = 24'hFFFFFF;
      3'd1:    bar_rgb_s = 24'hFFFF00;
      3'd2:    bar_rgb_s = 24'h00FFFF;
      3'd3:    bar_rgb_s = 24'h00FF00;
      3'd4:    bar_rgb_s = 24'hFF00FF;
      3'd5:    bar_rgb_s = 24'hFF0000;
      3'd6:    bar_rgb_s = 24'h0000FF;
      default: bar_rgb_s = 24'h000000;
    endcase

    if (de_d && pattern_en_i) begin
      rgb_d = bar_rgb_s;
    end else begin
      rgb_d = 24'h000000;
    end
  end

  // Pattern output register, aligned with de_o
  always_ff @(posedge pixel_clk_i) begin
    if (!rst_n_i) begin
      rgb_q <= 24'h000000;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign rgb_o = rgb_q;
`endif

endmodule
